mem_wb_writeback: RTL and testbench

//   MEM/WB pipeline register plus write-back stage, directly downstream of the memory stage.

---
 rtl/mem_wb_writeback.sv | 104 ++++++++++
 tb/tb_mem_wb_writeback.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and write-back select: registers the memory-stage result,
// drives the register-file write port, and tracks halt and retired-instruction count.
module mem_wb_writeback #(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 5,
  parameter int NB_COUNT = 32,
  parameter int LINK_REG = 31
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_flush,
  input  logic                i_valid,
  input  logic [NB_DATA-1:0]  i_output_mem,
  input  logic [NB_DATA-1:0]  i_ALU_res,
  input  logic [NB_ADDR-1:0]  i_addr_reg_dst,
  input  logic [NB_DATA-1:0]  i_pc_to_reg,
  input  logic                is_select_addr_reg,
  input  logic                is_write_pc,
  input  logic                is_RegWrite,
  input  logic                is_MemtoReg,
  input  logic                is_halt,
  output logic [NB_DATA-1:0]  o_wb_data,
  output logic [NB_ADDR-1:0]  o_wb_addr,
  output logic                os_wb_RegWrite,
  output logic                o_valid,
  output logic                os_halt,
  output logic [NB_COUNT-1:0] o_retired_count
);

  // Link value beats load data, which beats the ALU result.
  function automatic logic [NB_DATA-1:0] sel_wb_data(
    input logic               write_pc,
    input logic               mem_to_reg,
    input logic [NB_DATA-1:0] pc_val,
    input logic [NB_DATA-1:0] mem_val,
    input logic [NB_DATA-1:0] alu_val
  );
    if (write_pc)        return pc_val;
    else if (mem_to_reg) return mem_val;
    else                 return alu_val;
  endfunction

  function automatic logic [NB_ADDR-1:0] sel_wb_addr(
    input logic               select_link,
    input logic [NB_ADDR-1:0] dst
  );
    return select_link ? NB_ADDR'(LINK_REG) : dst;
  endfunction

  logic [NB_DATA-1:0]  wb_data_p1;
  logic [NB_ADDR-1:0]  wb_addr_p1;
  logic                we_p1;
  logic                vld_p1;
  logic                halt_p1;
  logic [NB_COUNT-1:0] count_p1;

  logic [NB_ADDR-1:0]  addr_p0;
  logic [NB_DATA-1:0]  data_p0;
  logic                we_p0;
  logic                adv;

  assign adv     = i_enable & ~halt_p1;
  assign addr_p0 = sel_wb_addr(is_select_addr_reg, i_addr_reg_dst);
  assign data_p0 = sel_wb_data(is_write_pc, is_MemtoReg, i_pc_to_reg, i_output_mem, i_ALU_res);
  // HALT and writes to r0 never reach the register file.
  assign we_p0   = i_valid & is_RegWrite & ~is_halt & (addr_p0 != '0);

  // ---- p0 -> p1: MEM/WB register ----
  always_ff @(posedge clk) begin
    if (i_reset) begin
      wb_data_p1 <= '0;
      wb_addr_p1 <= '0;
      we_p1      <= 1'b0;
      vld_p1     <= 1'b0;
      halt_p1    <= 1'b0;
      count_p1   <= '0;
    end else if (adv) begin
      if (i_flush) begin
        wb_data_p1 <= '0;
        wb_addr_p1 <= '0;
        we_p1      <= 1'b0;
        vld_p1     <= 1'b0;
      end else begin
        wb_data_p1 <= data_p0;
        wb_addr_p1 <= addr_p0;
        we_p1      <= we_p0;
        vld_p1     <= i_valid;
        if (i_valid) begin
          count_p1 <= count_p1 + 1'b1;
          if (is_halt) halt_p1 <= 1'b1;
        end
      end
    end
  end

  assign o_wb_data       = wb_data_p1;
  assign o_wb_addr       = wb_addr_p1;
  assign os_wb_RegWrite  = we_p1;
  assign o_valid         = vld_p1;
  assign os_halt         = halt_p1;
  assign o_retired_count = count_p1;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: vector table plus reset, wrap and flush/halt sequences.
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_flush, i_valid;
  logic [31:0] i_output_mem, i_ALU_res, i_pc_to_reg;
  logic [4:0]  i_addr_reg_dst;
  logic        is_select_addr_reg, is_write_pc, is_RegWrite, is_MemtoReg, is_halt;
  logic [31:0] o_wb_data, o_retired_count;
  logic [4:0]  o_wb_addr;
  logic        os_wb_RegWrite, o_valid, os_halt;
  logic [31:0] w_wb_data;
  logic [4:0]  w_wb_addr;
  logic        w_we, w_valid, w_halt;
  logic [3:0]  w_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_wb_writeback dut (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush), .i_valid(i_valid),
    .i_output_mem(i_output_mem), .i_ALU_res(i_ALU_res), .i_addr_reg_dst(i_addr_reg_dst),
    .i_pc_to_reg(i_pc_to_reg), .is_select_addr_reg(is_select_addr_reg), .is_write_pc(is_write_pc),
    .is_RegWrite(is_RegWrite), .is_MemtoReg(is_MemtoReg), .is_halt(is_halt),
    .o_wb_data(o_wb_data), .o_wb_addr(o_wb_addr), .os_wb_RegWrite(os_wb_RegWrite),
    .o_valid(o_valid), .os_halt(os_halt), .o_retired_count(o_retired_count)
  );

  mem_wb_writeback #(.NB_COUNT(4)) dut_w (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush), .i_valid(i_valid),
    .i_output_mem(i_output_mem), .i_ALU_res(i_ALU_res), .i_addr_reg_dst(i_addr_reg_dst),
    .i_pc_to_reg(i_pc_to_reg), .is_select_addr_reg(is_select_addr_reg), .is_write_pc(is_write_pc),
    .is_RegWrite(is_RegWrite), .is_MemtoReg(is_MemtoReg), .is_halt(is_halt),
    .o_wb_data(w_wb_data), .o_wb_addr(w_wb_addr), .os_wb_RegWrite(w_we),
    .o_valid(w_valid), .os_halt(w_halt), .o_retired_count(w_count)
  );

  typedef struct {
    string       name;
    logic        en, fl, v;
    logic [31:0] mem, alu, pc;
    logic [4:0]  dst;
    logic        sel, wpc, rw, m2r, hlt;
    logic [31:0] e_data;
    logic [4:0]  e_addr;
    logic        e_we, e_v, e_h;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(string nm, logic en, logic fl, logic v, logic [31:0] mem,
                              logic [31:0] alu, logic [31:0] pc, logic [4:0] dst, logic sel,
                              logic wpc, logic rw, logic m2r, logic hlt, logic [31:0] e_data,
                              logic [4:0] e_addr, logic e_we, logic e_v, logic e_h,
                              logic [31:0] e_cnt);
    vec_t r;
    r.name = nm; r.en = en; r.fl = fl; r.v = v; r.mem = mem; r.alu = alu; r.pc = pc;
    r.dst = dst; r.sel = sel; r.wpc = wpc; r.rw = rw; r.m2r = m2r; r.hlt = hlt;
    r.e_data = e_data; r.e_addr = e_addr; r.e_we = e_we; r.e_v = e_v; r.e_h = e_h;
    r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic fl, input logic v, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [4:0] dst,
                       input logic sel, input logic wpc, input logic rw, input logic m2r,
                       input logic hlt);
    i_enable = en; i_flush = fl; i_valid = v; i_output_mem = mem; i_ALU_res = alu;
    i_pc_to_reg = pc; i_addr_reg_dst = dst; is_select_addr_reg = sel; is_write_pc = wpc;
    is_RegWrite = rw; is_MemtoReg = m2r; is_halt = hlt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [31:0] d, input logic [4:0] a,
                         input logic we, input logic v, input logic h, input logic [31:0] c);
    chk({nm, ".data"},  64'(o_wb_data), 64'(d));
    chk({nm, ".addr"},  64'(o_wb_addr), 64'(a));
    chk({nm, ".we"},    64'(os_wb_RegWrite), 64'(we));
    chk({nm, ".valid"}, 64'(o_valid), 64'(v));
    chk({nm, ".halt"},  64'(os_halt), 64'(h));
    chk({nm, ".count"}, 64'(o_retired_count), 64'(c));
  endtask

  initial begin
    //             name     en fl v  mem           alu           pc     dst sel wpc rw m2r hlt  e_data        e_addr we v h cnt
    vecs[0]  = mk("alu",    1, 0, 1, 32'h0,        32'h1234,     32'h0,  5, 0, 0, 1, 0, 0, 32'h1234,     5,  1, 1, 0, 1);
    vecs[1]  = mk("load",   1, 0, 1, 32'hDEADBEEF, 32'h1111,     32'h0,  7, 0, 0, 1, 1, 0, 32'hDEADBEEF, 7,  1, 1, 0, 2);
    vecs[2]  = mk("link",   1, 0, 1, 32'hDEADBEEF, 32'h2222,     32'h40, 3, 1, 1, 1, 1, 0, 32'h40,       31, 1, 1, 0, 3);
    vecs[3]  = mk("stall1", 0, 0, 1, 32'h0,        32'h9999,     32'h0,  9, 0, 0, 1, 0, 0, 32'h40,       31, 1, 1, 0, 3);
    vecs[4]  = mk("stall2", 0, 1, 1, 32'h0,        32'h9999,     32'h0,  9, 0, 0, 1, 0, 0, 32'h40,       31, 1, 1, 0, 3);
    vecs[5]  = mk("stall3", 0, 0, 1, 32'h0,        32'h9999,     32'h0,  9, 0, 0, 1, 0, 1, 32'h40,       31, 1, 1, 0, 3);
    vecs[6]  = mk("flush",  1, 1, 1, 32'h0,        32'h9999,     32'h0,  9, 0, 0, 1, 0, 0, 32'h0,        0,  0, 0, 0, 3);
    vecs[7]  = mk("r0",     1, 0, 1, 32'h0,        32'h55,       32'h0,  0, 0, 0, 1, 0, 0, 32'h55,       0,  0, 1, 0, 4);
    vecs[8]  = mk("invld",  1, 0, 0, 32'h0,        32'h77,       32'h0,  4, 0, 0, 1, 0, 1, 32'h77,       4,  0, 0, 0, 4);
    vecs[9]  = mk("norw",   1, 0, 1, 32'h0,        32'h88,       32'h0,  6, 0, 0, 0, 0, 0, 32'h88,       6,  0, 1, 0, 5);
    vecs[10] = mk("halt",   1, 0, 1, 32'h0,        32'hAA,       32'h0,  8, 0, 0, 1, 0, 1, 32'hAA,       8,  0, 1, 1, 6);
    vecs[11] = mk("frz1",   1, 0, 1, 32'h0,        32'h123,      32'h0,  2, 0, 0, 1, 0, 0, 32'hAA,       8,  0, 1, 1, 6);
    vecs[12] = mk("frz2",   1, 1, 1, 32'h0,        32'h456,      32'h0, 12, 0, 0, 1, 0, 0, 32'hAA,       8,  0, 1, 1, 6);

    i_reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    i_reset = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].en, vecs[i].fl, vecs[i].v, vecs[i].mem, vecs[i].alu, vecs[i].pc,
            vecs[i].dst, vecs[i].sel, vecs[i].wpc, vecs[i].rw, vecs[i].m2r, vecs[i].hlt);
      step();
      chk_all(vecs[i].name, vecs[i].e_data, vecs[i].e_addr, vecs[i].e_we, vecs[i].e_v,
              vecs[i].e_h, vecs[i].e_cnt);
    end

    // Reset clears the halted state
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk_all("halt_reset", 0, 0, 0, 0, 0, 0);

    // Reset drops an in-flight write
    drive(1, 0, 1, 0, 32'hCAFE, 0, 10, 0, 0, 1, 0, 0);
    step();
    chk_all("pre_rst", 32'hCAFE, 10, 1, 1, 0, 1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk_all("mid_rst", 0, 0, 0, 0, 0, 0);

    // 17 retirements: 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 1, 0, 32'(i), 0, 1, 0, 0, 1, 0, 0);
      step();
    end
    chk("wrap.count4", 64'(w_count), 64'd1);
    chk("wrap.count32", 64'(o_retired_count), 64'd17);
    chk("wrap.we", 64'(w_we), 64'd1);

    // Flush and halt together: flush wins, pipeline keeps advancing
    drive(1, 1, 1, 0, 32'hBB, 0, 3, 0, 0, 1, 0, 1);
    step();
    chk_all("fl_halt", 0, 0, 0, 0, 0, 17);
    drive(1, 0, 1, 0, 32'hCC, 0, 3, 0, 0, 1, 0, 0);
    step();
    chk_all("after_fh", 32'hCC, 3, 1, 1, 0, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
